fetch_queue: RTL and testbench
==============================

# fetch_queue

Instruction fetch front end for the 5-stage core. Owns the fetch PC, issues reads to the 1-cycle synchronous instruction memory, and buffers returned words with their PCs in a small FIFO. Presents them to the IF/ID register through a valid/ready handshake, replacing the bare PC + prefetch buffer pair. Supports branch/jump redirect with flush, so a later EX-stage branch unit can steer fetch.

## Interface

- `D_WIDTH`, 32, instruction width
- `A_WIDTH`, 32, address width
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `RESET_PC`, 0, first fetch address after reset
- `clk`  in  1  clock; all state on rising edge
- `rst`  in  1  asynchronous, active-low reset (0 = reset)
- `imem_en`  out  1  read request to instruction memory this cycle
- `imem_addr`  out  A_WIDTH  byte address of the request
- `imem_rdata`  in  D_WIDTH  read data; valid the cycle after a cycle with `imem_en`=1
- `redirect`  in  1  flush and restart fetch at `redirect_pc`
- `redirect_pc`  in  A_WIDTH  redirect target; word aligned
- `out_valid`  out  1  head entry valid
- `out_instr`  out  D_WIDTH  head instruction
- `out_pc`  out  A_WIDTH  PC of head instruction
- `out_ready`  in  1  decode accepts head; low during load-use stall
- `count`  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation

- State: `fetch_pc`, `inflight` flag, `inflight_pc`, FIFO storage, rd/wr pointers, `count`.
- `pop` = `out_valid` & `out_ready` & ~`redirect`.
- `push` = `inflight` & ~`redirect`. Push data is {`imem_rdata`, `inflight_pc`}.
- Issue rule: `imem_en` = `redirect` | ((`count` + `inflight` − `pop`) < `DEPTH`). This rule guarantees no overflow. The combinational path `out_ready` → `imem_en` is intentional and gives full throughput.
- `imem_addr` = `redirect` ? `redirect_pc` : `fetch_pc`.
- On issue: `inflight` ← 1, `inflight_pc` ← `imem_addr`, `fetch_pc` ← `imem_addr` + 4. Otherwise `inflight` ← 0 and `fetch_pc` holds.
- Redirect has the highest priority. In the redirect cycle:
  - `count`, rd/wr pointers ← 0.
  - Any response arriving that cycle is discarded.
  - `out_valid` is forced to 0 combinationally, so there is no pop.
  - The target is issued in the same cycle.
- Simultaneous push and pop: `count` unchanged, both pointers advance.
- Pop when empty cannot occur, because `out_valid` = (`count` ≠ 0).
- Push when full cannot occur under the issue rule. A bench assertion checks this.
- Arithmetic:
  - `fetch_pc` wraps modulo 2^A_WIDTH.
  - Pointers wrap modulo DEPTH.
  - `count` ranges 0..DEPTH.
- Order: instructions leave in strictly increasing-PC order between redirects. There are no duplicates and no gaps.

## Timing

- Reset (`rst`=0, asynchronous): `fetch_pc`=`RESET_PC`, `inflight`=0, `count`=0, pointers 0, storage 0.
  - `out_valid`=0, `out_instr`=0, `out_pc`=0, `count`=0.
  - `imem_en`=0 while `rst`=0.
- Reset release: the first clock cycle with `rst`=1 issues `RESET_PC`.
- Fetch latency: issue in cycle N, data at `imem_rdata` in N+1, pushed at the end of N+1, `out_valid` in N+2.
- Redirect latency: redirect asserted in cycle N → `out_valid`=0 in N+1 → target at head in N+2.
- Steady state with `out_ready`=1: one instruction per cycle for any DEPTH ≥2.
- Backpressure: with `out_ready`=0, issue stops once `count` + `inflight` = DEPTH. The head and its PC stay stable until accepted.
- Reset asserted mid-operation: all state clears immediately without a clock edge. In-flight data is lost.

## Test plan

- Reset then release, `out_ready`=1, memory returns word = addr ^ 0xA5A5_0000 → `out_valid` rises 2 cycles after release with `out_pc`=0x0. After that, `out_pc` is 0x4, 0x8, … every cycle, and `out_instr` matches.
- Hold `out_ready`=0 from release → `count` saturates at 4, `imem_en`=0 from then on, exactly 4 issues seen. Then release `out_ready` → PCs 0x0, 0x4, 0x8, 0xC, 0x10, … are delivered with no gap or duplicate.
- With FIFO full, pulse `redirect`=1 with `redirect_pc`=0x40 → `imem_addr`=0x40 that cycle, `out_valid`=0 and `count`=0 next cycle, then `out_pc`=0x40 the following cycle, followed by 0x44.
- Redirect to 0x80 in a cycle with a response arriving and `out_ready`=1 → the response is never delivered, no pop occurs in that cycle, and the next delivered PC is 0x80.
- Assert `rst`=0 between clock edges mid-stream → `out_valid`, `count`, `imem_en` go 0 immediately. After release, fetch restarts at `RESET_PC`.
- `RESET_PC`=0xFFFF_FFF8 → delivered PCs are 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.

Source files
------------

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: bundles the instruction-memory request/response pair, the
// redirect request and the decode-side valid/ready handshake of fetch_queue.
//
// Signals:
//   imem_en, imem_addr   fetch queue -> instruction memory read request
//   imem_rdata           instruction memory -> fetch queue, one cycle after request
//   redirect, redirect_pc  branch unit -> fetch queue, flush and restart
//   out_valid, out_instr, out_pc  fetch queue -> decode, head entry
//   out_ready            decode -> fetch queue, head accepted
//   count                fetch queue occupancy
//
// Modports: master = fetch queue side, slave = environment (memory/decode/branch).
interface fetch_queue_if #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 32,
    parameter int DEPTH   = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic               imem_en;
    logic [A_WIDTH-1:0] imem_addr;
    logic [D_WIDTH-1:0] imem_rdata;
    logic               redirect;
    logic [A_WIDTH-1:0] redirect_pc;
    logic               out_valid;
    logic [D_WIDTH-1:0] out_instr;
    logic [A_WIDTH-1:0] out_pc;
    logic               out_ready;
    logic [CNT_W-1:0]   count;

    modport master (
        output imem_en, imem_addr, out_valid, out_instr, out_pc, count,
        input  imem_rdata, redirect, redirect_pc, out_ready
    );

    modport slave (
        input  imem_en, imem_addr, out_valid, out_instr, out_pc, count,
        output imem_rdata, redirect, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end. Owns the fetch PC, issues reads to
// a 1-cycle synchronous instruction memory, buffers returned words together
// with their PCs in a DEPTH-entry FIFO and presents the head to decode through
// a valid/ready handshake. A redirect flushes the FIFO, drops any response in
// flight and issues the target in the same cycle.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous, active-low reset (0 = reset)
//   bus   fetch_queue_if.master: imem_en/imem_addr/imem_rdata,
//         redirect/redirect_pc, out_valid/out_instr/out_pc/out_ready, count
module fetch_queue #(
    parameter int                 D_WIDTH  = 32,
    parameter int                 A_WIDTH  = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [A_WIDTH-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               CNT_W    = PTR_W + 1;
    localparam logic [CNT_W:0]   FULL_LVL = DEPTH[CNT_W:0];

    logic [A_WIDTH-1:0] fetch_pc;
    logic               inflight;
    logic [A_WIDTH-1:0] inflight_pc;
    logic [D_WIDTH-1:0] instr_q [DEPTH];
    logic [A_WIDTH-1:0] pc_q    [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;

    logic               head_valid;
    logic               pop;
    logic               push;
    logic               issue;
    logic [CNT_W:0]     pending;
    logic [A_WIDTH-1:0] issue_addr;

    always_comb begin
        head_valid = (count != '0) && !bus.redirect;
        pop        = head_valid && bus.out_ready;
        push       = inflight && !bus.redirect;
        // Occupancy after this cycle's pop plus the word still in flight;
        // issuing only while it is below DEPTH is what makes overflow
        // impossible. The out_ready -> imem_en path keeps full throughput.
        pending    = {1'b0, count}
                   + {{CNT_W{1'b0}}, inflight}
                   - {{CNT_W{1'b0}}, pop};
        // Reset gates the request so memory sees no read while rst is low.
        issue      = rst && (bus.redirect || (pending < FULL_LVL));
        issue_addr = bus.redirect ? bus.redirect_pc : fetch_pc;
    end

    assign bus.imem_en   = issue;
    assign bus.imem_addr = issue_addr;
    assign bus.out_valid = head_valid;
    assign bus.out_instr = instr_q[rd_ptr];
    assign bus.out_pc    = pc_q[rd_ptr];
    assign bus.count     = count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= issue_addr;
                fetch_pc    <= issue_addr + A_WIDTH'(4);
            end

            if (bus.redirect) begin
                // Flush: the response arriving now belongs to the old path.
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    instr_q[wr_ptr] <= bus.imem_rdata;
                    pc_q[wr_ptr]    <= inflight_pc;
                    wr_ptr          <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (push && !pop) begin
                    count <= count + CNT_W'(1);
                end else if (pop && !push) begin
                    count <= count - CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: self-checking bench for fetch_queue. A behavioural memory
// returns addr ^ 0xA5A5_0000 one cycle after each request (random garbage
// otherwise). A reference scoreboard tracks the next PC decode must receive:
// it starts at RESET_PC, advances by 4 per accepted instruction and jumps to
// the redirect target on a redirect. Directed steps cover reset, latency,
// backpressure, redirects and asynchronous reset; a random phase follows. A
// second instance with RESET_PC = 0xFFFF_FFF8 checks PC wrap-around.
module tb_fetch_queue;
    localparam logic [31:0] XOR_PAT = 32'hA5A5_0000;

    logic clk;
    logic rst;
    logic rst_w;

    fetch_queue_if #(.D_WIDTH(32), .A_WIDTH(32), .DEPTH(4)) bus ();
    fetch_queue_if #(.D_WIDTH(32), .A_WIDTH(32), .DEPTH(4)) bus_w ();

    fetch_queue #(.D_WIDTH(32), .A_WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fetch_queue #(.D_WIDTH(32), .A_WIDTH(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk (clk),
        .rst (rst_w),
        .bus (bus_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_rdata <= bus.imem_addr ^ XOR_PAT;
        else             bus.imem_rdata <= $urandom;
    end

    always @(posedge clk) begin
        if (bus_w.imem_en) bus_w.imem_rdata <= bus_w.imem_addr ^ XOR_PAT;
        else               bus_w.imem_rdata <= $urandom;
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_issue = 0;
    int          n_deliv = 0;
    logic [31:0] exp_pc;
    logic        hold_prev;
    logic [31:0] hold_pc;
    logic        prev_issue;
    logic        s_en;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_pc;
    logic [2:0]  s_count;
    logic [31:0] wq_pc[$];
    logic [31:0] wq_instr[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic reset_model();
        exp_pc     = 32'h0;
        hold_prev  = 1'b0;
        prev_issue = 1'b0;
    endtask

    // One clock cycle: drive inputs just after the rising edge, sample and
    // score on the falling edge, return just after the next rising edge.
    task automatic cycle(input logic rdy, input logic redir, input logic [31:0] rpc);
        bus.out_ready   = rdy;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        @(negedge clk);
        s_en    = bus.imem_en;
        s_addr  = bus.imem_addr;
        s_valid = bus.out_valid;
        s_pc    = bus.out_pc;
        s_count = bus.count;
        if (s_en) n_issue++;
        check("count_range", bus.count <= 3'd4, 1'b1);
        if (prev_issue && !redir && !(bus.out_valid && rdy))
            check("no_overflow", bus.count < 3'd4, 1'b1);
        if (hold_prev && !redir) begin
            check("hold_valid", bus.out_valid, 1'b1);
            check("hold_pc", bus.out_pc, hold_pc);
        end
        if (redir) begin
            check("redir_valid", bus.out_valid, 1'b0);
            check("redir_en", bus.imem_en, 1'b1);
            check("redir_addr", bus.imem_addr, rpc);
            exp_pc = rpc;
        end else if (bus.out_valid && rdy) begin
            check("deliv_pc", bus.out_pc, exp_pc);
            check("deliv_instr", bus.out_instr, exp_pc ^ XOR_PAT);
            exp_pc = exp_pc + 32'd4;
            n_deliv++;
        end
        hold_prev  = bus.out_valid && !rdy && !redir;
        hold_pc    = bus.out_pc;
        prev_issue = bus.imem_en;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int d0;
        logic        r_rdy;
        logic        r_redir;
        logic [31:0] r_pc;

        rst   = 1'b1;
        rst_w = 1'b1;
        bus.out_ready     = 1'b0;
        bus.redirect      = 1'b0;
        bus.redirect_pc   = 32'h0;
        bus_w.out_ready   = 1'b1;
        bus_w.redirect    = 1'b0;
        bus_w.redirect_pc = 32'h0;
        reset_model();
        #1;
        rst   = 1'b0;
        rst_w = 1'b0;
        #1;
        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_count", bus.count, 3'd0);
        check("rst_en", bus.imem_en, 1'b0);
        check("rst_instr", bus.out_instr, 32'h0);
        check("rst_pc", bus.out_pc, 32'h0);

        // Release and stream with out_ready held high.
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle(1'b1, 1'b0, 32'h0);
        check("t1_first_en", s_en, 1'b1);
        check("t1_first_addr", s_addr, 32'h0);
        check("t1_c0_valid", s_valid, 1'b0);
        cycle(1'b1, 1'b0, 32'h0);
        check("t1_c1_valid", s_valid, 1'b0);
        cycle(1'b1, 1'b0, 32'h0);
        check("t1_c2_valid", s_valid, 1'b1);
        check("t1_c2_pc", s_pc, 32'h0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 32'h0);
            check("t1_stream_valid", s_valid, 1'b1);
        end

        // Asynchronous reset between clock edges.
        rst = 1'b0;
        #1;
        check("arst_valid", bus.out_valid, 1'b0);
        check("arst_count", bus.count, 3'd0);
        check("arst_en", bus.imem_en, 1'b0);
        reset_model();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Backpressure from release: exactly DEPTH issues, then stall.
        n_issue = 0;
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 32'h0);
        check("bp_issues", n_issue, 4);
        check("bp_count", s_count, 3'd4);
        check("bp_en", s_en, 1'b0);
        check("bp_head_valid", s_valid, 1'b1);
        check("bp_head_pc", s_pc, 32'h0);
        d0 = n_deliv;
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 32'h0);
        check("bp_drain_n", n_deliv - d0, 8);

        // Redirect with the FIFO full.
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 32'h0);
        check("full_count", s_count, 3'd4);
        cycle(1'b0, 1'b1, 32'h40);
        cycle(1'b0, 1'b0, 32'h0);
        check("rf_n1_valid", s_valid, 1'b0);
        check("rf_n1_count", s_count, 3'd0);
        cycle(1'b0, 1'b0, 32'h0);
        check("rf_n2_valid", s_valid, 1'b1);
        check("rf_n2_pc", s_pc, 32'h40);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        check("rf_second_pc", s_pc, 32'h44);

        // Redirect while streaming: response in flight is dropped.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0);
        d0 = n_deliv;
        cycle(1'b1, 1'b1, 32'h80);
        check("rs_no_pop", n_deliv - d0, 0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0);
        check("rs_deliv_n", n_deliv - d0, 3);
        check("rs_last_pc", s_pc, 32'h88);

        // Random ready/redirect mix against the scoreboard.
        d0 = n_deliv;
        for (int i = 0; i < 400; i++) begin
            r_rdy   = ($urandom_range(0, 9) < 7);
            r_redir = ($urandom_range(0, 19) == 0);
            r_pc    = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) r_pc = 32'hFFFF_FFF0 | (r_pc & 32'hC);
            cycle(r_rdy, r_redir, r_pc);
        end
        check("rand_progress", (n_deliv - d0) > 100, 1'b1);

        // PC wrap-around on the second instance.
        rst_w = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus_w.out_valid) begin
                wq_pc.push_back(bus_w.out_pc);
                wq_instr.push_back(bus_w.out_instr);
            end
            @(posedge clk);
            #1;
        end
        check("wrap_n", wq_pc.size() >= 4, 1'b1);
        if (wq_pc.size() >= 4) begin
            check("wrap_pc0", wq_pc[0], 32'hFFFF_FFF8);
            check("wrap_pc1", wq_pc[1], 32'hFFFF_FFFC);
            check("wrap_pc2", wq_pc[2], 32'h0000_0000);
            check("wrap_pc3", wq_pc[3], 32'h0000_0004);
            check("wrap_instr0", wq_instr[0], 32'hFFFF_FFF8 ^ XOR_PAT);
            check("wrap_instr2", wq_instr[2], 32'h0000_0000 ^ XOR_PAT);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
